// File: rtl/cpu_control_sequencer.sv
// ---------------------------------------------------------------------------------------------
// cpu_control_sequencer
//
// Multicycle control sequencer for the single-issue CPU datapath. Each instruction walks
// FETCH -> DECODE -> EXECUTE -> WRITEBACK, one state per cycle. The fetch can stall for any
// number of cycles on imem_ready. An unsupported encoding parks the sequencer in TRAP until
// reset.
//
// Only ARM-style data-processing instructions are supported: ADD, SUB, AND, ORR and CMP. Each
// may use a register or a rotated 8-bit immediate operand and any condition code except 1111.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous active-high reset
//   imem_req     out  1   fetch request (FETCH and not in reset)
//   imem_ready   in   1   imem_rdata valid; only looked at in FETCH
//   imem_rdata   in   32  instruction word
//   alu_flags    in   4   NZCV produced by the ALU during EXECUTE
//   ra1          out  4   register file A1 = IR[19:16] (Rn)
//   ra2          out  4   register file A2 = IR[3:0]   (Rm)
//   wa3          out  4   register file A3 = IR[15:12] (Rd)
//   reg_we       out  1   register file WE3, WRITEBACK pulse
//   alu_src_imm  out  1   ALU B operand select: 1 = imm_out, 0 = RD2
//   imm_out      out  32  IR[7:0] zero-extended, rotated right by 2*IR[11:8]
//   alu_control  out  4   ADD 0000, SUB 0001, AND 0010, ORR 0011
//   pc_we        out  1   PC advance strobe, WRITEBACK pulse
//   flags        out  4   architectural NZCV register
//   retired      out  1   one pulse per completed (or condition-failed) instruction
//   illegal      out  1   sticky unsupported-encoding indicator
// ---------------------------------------------------------------------------------------------
module cpu_control_sequencer #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  ra1,
    output logic [3:0]  ra2,
    output logic [3:0]  wa3,
    output logic        reg_we,
    output logic        alu_src_imm,
    output logic [31:0] imm_out,
    output logic [3:0]  alu_control,
    output logic        pc_we,
    output logic [3:0]  flags,
    output logic        retired,
    output logic        illegal
);

    localparam logic [2:0] StFetch     = 3'd0;
    localparam logic [2:0] StDecode    = 3'd1;
    localparam logic [2:0] StExecute   = 3'd2;
    localparam logic [2:0] StWriteback = 3'd3;
    localparam logic [2:0] StTrap      = 3'd4;

    localparam logic [3:0] CmdAnd = 4'b0000;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdCmp = 4'b1010;
    localparam logic [3:0] CmdOrr = 4'b1100;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0010;
    localparam logic [3:0] AluOrr = 4'b0011;

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    logic [2:0]  state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  flags_q, flags_d;
    logic        illegal_q, illegal_d;
    // Condition result captured in DECODE. EXECUTE may rewrite the flags, so WRITEBACK must
    // not re-evaluate the condition against the updated NZCV.
    logic        cond_ok_q, cond_ok_d;

    // -----------------------------------------------------------------------------------------
    // Instruction fields
    // -----------------------------------------------------------------------------------------
    logic [3:0] f_cond;
    logic [1:0] f_op;
    logic       f_imm;
    logic [3:0] f_cmd;
    logic       f_s;
    logic [3:0] f_rn;
    logic [3:0] f_rd;
    logic [3:0] f_rot;
    logic [7:0] f_imm8;
    logic [7:0] f_shift;
    logic [3:0] f_rm;

    assign f_cond  = ir_q[31:28];
    assign f_op    = ir_q[27:26];
    assign f_imm   = ir_q[25];
    assign f_cmd   = ir_q[24:21];
    assign f_s     = ir_q[20];
    assign f_rn    = ir_q[19:16];
    assign f_rd    = ir_q[15:12];
    assign f_rot   = ir_q[11:8];
    assign f_imm8  = ir_q[7:0];
    assign f_shift = ir_q[11:4];
    assign f_rm    = ir_q[3:0];

    logic is_cmp;
    assign is_cmp = (f_cmd == CmdCmp);

    // -----------------------------------------------------------------------------------------
    // Legality
    // -----------------------------------------------------------------------------------------
    logic cmd_known;
    logic legal;

    always_comb begin
        cmd_known = 1'b0;
        case (f_cmd)
            CmdAnd, CmdSub, CmdAdd, CmdCmp, CmdOrr: cmd_known = 1'b1;
            default:                                cmd_known = 1'b0;
        endcase
    end

    // Register-operand forms must carry no shift (IR[11:4] == 0).
    // CMP only makes sense with S set.
    // Writing R15 would bypass the PC sequencing, so Rd=15 is rejected.
    assign legal = (f_op == 2'b00)
                 && cmd_known
                 && (f_cond != 4'b1111)
                 && (f_imm || (f_shift == 8'h00))
                 && (!is_cmp || f_s)
                 && (is_cmp || (f_rd != 4'd15));

    // -----------------------------------------------------------------------------------------
    // Condition evaluation on the architectural flags (N = [3], Z = [2], C = [1], V = [0])
    // -----------------------------------------------------------------------------------------
    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    always_comb begin
        cond_pass = 1'b0;
        case (f_cond)
            4'b0000: cond_pass = flag_z;                              // EQ
            4'b0001: cond_pass = !flag_z;                             // NE
            4'b0010: cond_pass = flag_c;                              // CS
            4'b0011: cond_pass = !flag_c;                             // CC
            4'b0100: cond_pass = flag_n;                              // MI
            4'b0101: cond_pass = !flag_n;                             // PL
            4'b0110: cond_pass = flag_v;                              // VS
            4'b0111: cond_pass = !flag_v;                             // VC
            4'b1000: cond_pass = flag_c && !flag_z;                   // HI
            4'b1001: cond_pass = !flag_c || flag_z;                   // LS
            4'b1010: cond_pass = (flag_n == flag_v);                  // GE
            4'b1011: cond_pass = (flag_n != flag_v);                  // LT
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);       // GT
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);        // LE
            4'b1110: cond_pass = 1'b1;                                // AL
            default: cond_pass = 1'b0;                                // 1111 is trapped anyway
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        cond_ok_d = cond_ok_q;

        case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (legal) begin
                    cond_ok_d = cond_pass;
                    state_d   = StExecute;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StTrap;
                end
            end
            StExecute: begin
                if (cond_ok_q && (f_s || is_cmp)) begin
                    flags_d = alu_flags;
                end
                state_d = StWriteback;
            end
            StWriteback: begin
                state_d = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StTrap;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            ir_q      <= 32'h0000_0000;
            flags_q   <= RESET_FLAGS;
            illegal_q <= 1'b0;
            cond_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            cond_ok_q <= cond_ok_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Datapath controls, combinational from IR in every state
    // -----------------------------------------------------------------------------------------
    logic [63:0] imm_dbl;
    logic [63:0] imm_rot;

    // Rotate right implemented as a shift of the doubled word.
    assign imm_dbl = {24'h00_0000, f_imm8, 24'h00_0000, f_imm8};
    assign imm_rot = imm_dbl >> {f_rot, 1'b0};
    assign imm_out = imm_rot[31:0];

    always_comb begin
        alu_control = AluAdd;
        case (f_cmd)
            CmdAdd:         alu_control = AluAdd;
            CmdSub, CmdCmp: alu_control = AluSub;
            CmdAnd:         alu_control = AluAnd;
            CmdOrr:         alu_control = AluOrr;
            default:        alu_control = AluAdd;
        endcase
    end

    assign ra1         = f_rn;
    assign ra2         = f_rm;
    assign wa3         = f_rd;
    assign alu_src_imm = f_imm;

    // -----------------------------------------------------------------------------------------
    // Strobes and status
    // -----------------------------------------------------------------------------------------
    // The reset term keeps the request low while reset is held, even though state is FETCH.
    assign imem_req = (state_q == StFetch) && !reset;
    assign reg_we   = (state_q == StWriteback) && cond_ok_q && !is_cmp;
    assign pc_we    = (state_q == StWriteback);
    assign retired  = (state_q == StWriteback);
    assign flags    = flags_q;
    assign illegal  = illegal_q;

endmodule

// File: doc/cpu_control_sequencer.md
# cpu_control_sequencer

Multicycle control sequencer for the CPU datapath (program counter, instruction memory, register file, ALU). It fetches an instruction word through a request/ready handshake and latches it in an internal instruction register. It then decodes the ARM-style data-processing fields and evaluates the condition code against its own NZCV flag register. Finally it drives the register-file addresses and write enable, the ALU control and immediate, and the PC advance strobe, one state per cycle. It sits between the instruction memory and the existing register-file/ALU datapath and replaces the tied-high write enable used today.

## Interface
Parameters:
- `RESET_FLAGS`, 4'b0000, NZCV value loaded at reset.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_ready`  in  1  instruction memory has valid `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `alu_flags`  in  4  NZCV from the ALU, valid in EXECUTE.
- `ra1`  out  4  register-file A1 = IR[19:16] (Rn).
- `ra2`  out  4  register-file A2 = IR[3:0] (Rm).
- `wa3`  out  4  register-file A3 = IR[15:12] (Rd).
- `reg_we`  out  1  register-file WE3.
- `alu_src_imm`  out  1  1 = ALU B operand is `imm_out`, 0 = RD2.
- `imm_out`  out  32  IR[7:0] zero-extended and rotated right by 2*IR[11:8].
- `alu_control`  out  4  ADD 0000, SUB 0001, AND 0010, ORR 0011.
- `pc_we`  out  1  PC advance strobe (datapath computes PC+4).
- `flags`  out  4  current NZCV register.
- `retired`  out  1  one-cycle pulse per completed instruction.
- `illegal`  out  1  sticky; set on an unsupported encoding.

## Operation
- State register: FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
- FETCH:
  - `imem_req`=1.
  - On `imem_ready`=1, IR <= `imem_rdata` and the next state is DECODE.
  - Otherwise the sequencer stays in FETCH; the wait is unbounded.
- DECODE:
  - Evaluate legality and the condition.
  - Illegal encoding goes to TRAP; otherwise the next state is EXECUTE.
- Legal encoding requires all of:
  - IR[27:26]=00.
  - cmd IR[24:21] is one of ADD 0100, SUB 0010, AND 0000, ORR 1100, CMP 1010.
  - cond is not 1111.
  - When I=0 (IR[25]), IR[11:4]=0.
  - CMP has S=1.
  - For non-CMP commands, Rd is not 15.
- Condition uses the full ARM table on `flags`: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
- EXECUTE:
  - `alu_control` and `alu_src_imm`=I are driven.
  - If cond passes and (S=1 or cmd=CMP), `flags` <= `alu_flags` at the end of the cycle.
- WRITEBACK:
  - `reg_we`=1 iff cond passes and cmd is not CMP.
  - `pc_we`=1 and `retired`=1 unconditionally.
  - Next state is FETCH.
- Condition fail: no register or flag write, but `pc_we` and `retired` still pulse, so the instruction is retired as a no-op.
- TRAP:
  - `illegal`=1.
  - All strobes are 0; there is no fetch and no PC advance.
  - The sequencer stays in TRAP until `reset`.
- `ra1`, `ra2`, `wa3`, `imm_out`, `alu_control` and `alu_src_imm` are combinational from IR in every state. In FETCH, while IR still holds the previous instruction, they reflect that previous instruction.
- `imem_ready` outside FETCH is ignored.

## Timing
- Reset (asynchronous, immediate):
  - state=FETCH, IR=0, `flags`=`RESET_FLAGS`, `illegal`=0.
  - `reg_we`, `pc_we`, `retired`=0.
- Outputs while `reset` is high:
  - `imem_req` is 0 while `reset` is asserted and rises in the first cycle after deassertion.
  - Address and immediate outputs reflect IR=0.
- Latency: 4 cycles per instruction when `imem_ready` is returned in the same cycle as the request; 4+k cycles with k wait cycles.
- `reg_we`, `pc_we` and `retired` are one-cycle pulses, asserted only in WRITEBACK; flag updates happen only in EXECUTE.
- Reset in any state aborts the instruction. A pending register write is never performed, and the PC is not advanced.

## Test plan
- ADD register, back-to-back:
  - Stimulus: reset, then `imem_rdata`=0xE0812003 (ADD R2,R1,R3) with `imem_ready` high.
  - Response: `ra1`=1, `ra2`=3, `wa3`=2, `alu_control`=0000, `alu_src_imm`=0.
  - Response: `reg_we`, `pc_we` and `retired` pulse on cycle 4; `imem_req` returns high on cycle 5.
- ADD immediate with rotate:
  - Stimulus: 0xE2814C01 (ADD R4,R1,#0x100).
  - Response: `imm_out`=0x00000100, `alu_src_imm`=1, `wa3`=4.
- Flags and condition:
  - Stimulus: CMP R1,R1 (0xE1510001) with `alu_flags`=0100.
  - Response: `flags`=0100 after EXECUTE.
  - Stimulus: next, ADDNE (0x10812003).
  - Response: `reg_we`=0, `pc_we`=1, `retired`=1.
  - Stimulus: next, ADDEQ (0x00812003).
  - Response: `reg_we`=1.
- Fetch stall:
  - Stimulus: hold `imem_ready`=0 for 5 cycles.
  - Response: `imem_req` stays 1, no strobes, IR unchanged; the instruction completes 4 cycles after `imem_ready` rises.
- Illegal encodings:
  - Stimulus: 0xE5912000 (LDR) or 0xE080F003 (Rd=15).
  - Response: TRAP, `illegal`=1, `imem_req`=0 and no `pc_we` for 20 cycles; `reset` clears `illegal`.
- Reset mid-instruction:
  - Stimulus: assert `reset` during EXECUTE of an ADD.
  - Response: no `reg_we` pulse, `flags`=`RESET_FLAGS`, restart at FETCH.
